// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types and default widths used by the fetch unit, decoder and ROM.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int FETCH_IW = 9;
  localparam int FETCH_TW = 6;
  localparam int FETCH_CW = 16;

endpackage

// File: rtl/branch_lut.sv
// Absolute branch target table: 2**TW entries of IW bits, indexed by the decoder target field.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int IW = FETCH_IW,
  parameter int TW = FETCH_TW,
  // Entry k occupies bits [k*IW +: IW]; entries not set by the integrator are 0.
  parameter logic [(2**TW)*IW-1:0] LUT_INIT = '0
) (
  input  logic [TW-1:0] index,
  output logic [IW-1:0] target
);

  assign target = LUT_INIT[int'(index)*IW +: IW];

endmodule

// File: rtl/inst_fetch.sv
// Program counter / fetch sequencer: Start handshake, sequential fetch, relative and LUT branches,
// halt, end-of-ROM fault and saturating run-cycle counter.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int             IW        = FETCH_IW,
  parameter int             TW        = FETCH_TW,
  parameter int             CW        = FETCH_CW,
  parameter logic [IW-1:0]  PROG_BASE = '0,
  parameter logic [(2**TW)*IW-1:0] LUT_INIT = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchAbs,
  input  logic [TW-1:0] Target,
  output logic [IW-1:0] InstAddress,
  output logic          Running,
  output logic          Done,
  output logic          Fault,
  output logic [CW-1:0] CycleCount
);

  localparam logic [IW-1:0] PC_MAX = '1;

  fetch_state_t  state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] lut_target;

  function automatic logic [IW-1:0] sext_target(input logic [TW-1:0] t);
    return {{(IW-TW){t[TW-1]}}, t};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  branch_lut #(
    .IW       (IW),
    .TW       (TW),
    .LUT_INIT (LUT_INIT)
  ) u_branch_lut (
    .index  (Target),
    .target (lut_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (Start) begin
      // Start high reloads from any state, including mid-run.
      state_d = IDLE;
      pc_d    = PROG_BASE;
      fault_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          cnt_d = sat_inc(cnt_q);
          if (Halt) begin
            state_d = DONE;
          end else if (BranchEn) begin
            pc_d = BranchAbs ? lut_target : pc_q + sext_target(Target);
          end else if (pc_q == PC_MAX) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            pc_d = pc_q + IW'(1);
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= PROG_BASE;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign Running     = (state_q == RUN);
  assign Done        = (state_q == DONE);
  assign Fault       = fault_q;
  assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed, table-driven bench for inst_fetch plus hand sequences for fault, saturation and async reset.
module tb_inst_fetch;

  localparam logic [575:0] LUT = (576'(9'd200) << 18) | (576'(9'd20) << 45);

  logic       clk = 1'b0;
  logic       rst, start, halt, br_en, br_abs;
  logic [5:0] target;
  logic [8:0] addr;
  logic       running, done, fault;
  logic [15:0] cnt;

  logic       s_rst, s_start;
  logic [8:0] s_addr;
  logic       s_running, s_done, s_fault;
  logic [3:0] s_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch #(.LUT_INIT(LUT)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt), .BranchEn(br_en),
    .BranchAbs(br_abs), .Target(target), .InstAddress(addr), .Running(running),
    .Done(done), .Fault(fault), .CycleCount(cnt)
  );

  inst_fetch #(.CW(4)) dut_small (
    .Clk(clk), .Reset(s_rst), .Start(s_start), .Halt(1'b0), .BranchEn(1'b0),
    .BranchAbs(1'b0), .Target(6'd0), .InstAddress(s_addr), .Running(s_running),
    .Done(s_done), .Fault(s_fault), .CycleCount(s_cnt)
  );

  typedef struct {
    logic       start, halt, br_en, br_abs;
    logic [5:0] target;
    logic [8:0] e_addr;
    logic       e_run, e_done, e_fault;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic h, logic be, logic ba, logic [5:0] t,
                              logic [8:0] a, logic r, logic d, logic f, logic [15:0] c);
    vec_t v;
    v.start = s; v.halt = h; v.br_en = be; v.br_abs = ba; v.target = t;
    v.e_addr = a; v.e_run = r; v.e_done = d; v.e_fault = f; v.e_cnt = c;
    return v;
  endfunction

  task automatic check(string name, logic [8:0] ea, logic er, logic ed, logic ef, logic [15:0] ec);
    n_vec++;
    if ({addr, running, done, fault, cnt} !== {ea, er, ed, ef, ec}) begin
      n_err++;
      $display("FAIL %s: got addr=%0d run=%0b done=%0b fault=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b fault=%0b cnt=%0d",
               name, addr, running, done, fault, cnt, ea, er, ed, ef, ec);
    end
  endtask

  task automatic check_small(string name, logic [8:0] ea, logic er, logic [3:0] ec);
    n_vec++;
    if ({s_addr, s_running, s_cnt} !== {ea, er, ec}) begin
      n_err++;
      $display("FAIL %s: got addr=%0d run=%0b cnt=%0d, expected addr=%0d run=%0b cnt=%0d",
               name, s_addr, s_running, s_cnt, ea, er, ec);
    end
  endtask

  task automatic drive(logic s, logic h, logic be, logic ba, logic [5:0] t);
    start = s; halt = h; br_en = be; br_abs = ba; target = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1; s_start = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    #2;
    check("reset_state", 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b0; s_rst = 1'b0;

    // start/halt/branch/abs/target -> addr/run/done/fault/cnt after the edge
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd0,   1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd1,   1, 0, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd2,   1, 0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd3,   1, 0, 0, 16'd3));
    vecs.push_back(mk(0, 0, 1, 0, 6'd7,        9'd10,  1, 0, 0, 16'd4));
    vecs.push_back(mk(0, 0, 1, 0, 6'b111101,   9'd7,   1, 0, 0, 16'd5));
    vecs.push_back(mk(0, 0, 1, 0, 6'd5,        9'd12,  1, 0, 0, 16'd6));
    vecs.push_back(mk(0, 0, 1, 0, 6'b110101,   9'd1,   1, 0, 0, 16'd7));
    vecs.push_back(mk(0, 0, 1, 0, 6'b111101,   9'd510, 1, 0, 0, 16'd8));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd511, 1, 0, 0, 16'd9));
    vecs.push_back(mk(0, 0, 1, 0, 6'd5,        9'd4,   1, 0, 0, 16'd10));
    vecs.push_back(mk(0, 0, 1, 1, 6'd2,        9'd200, 1, 0, 0, 16'd11));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd201, 1, 0, 0, 16'd12));
    vecs.push_back(mk(0, 0, 1, 1, 6'd5,        9'd20,  1, 0, 0, 16'd13));
    vecs.push_back(mk(0, 1, 1, 0, 6'd5,        9'd20,  0, 1, 0, 16'd14));
    vecs.push_back(mk(0, 1, 1, 0, 6'd5,        9'd20,  0, 1, 0, 16'd14));
    vecs.push_back(mk(0, 0, 1, 1, 6'd2,        9'd20,  0, 1, 0, 16'd14));
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));
    vecs.push_back(mk(0, 1, 1, 0, 6'd3,        9'd0,   1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 1, 0, 0, 6'd0,        9'd0,   0, 1, 0, 16'd1));
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd0,   1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd1,   1, 0, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 6'd0,        9'd2,   1, 0, 0, 16'd2));
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 0, 6'd0,        9'd0,   0, 0, 0, 16'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].br_en, vecs[i].br_abs, vecs[i].target);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_run, vecs[i].e_done,
            vecs[i].e_fault, vecs[i].e_cnt);
    end

    // Sequential run off the end of the ROM.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    check("fault_launch", 9'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 511; k++) step();
    check("fault_at_top", 9'd511, 1'b1, 1'b0, 1'b0, 16'd511);
    step();
    check("fault_set", 9'd511, 1'b0, 1'b1, 1'b1, 16'd512);
    step();
    check("fault_hold", 9'd511, 1'b0, 1'b1, 1'b1, 16'd512);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    check("fault_clear", 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Narrow counter saturation.
    s_start = 1'b0;
    step();
    check_small("sat_launch", 9'd0, 1'b1, 4'd0);
    for (int k = 0; k < 14; k++) step();
    check_small("sat_14", 9'd14, 1'b1, 4'd14);
    step();
    check_small("sat_15", 9'd15, 1'b1, 4'd15);
    for (int k = 0; k < 5; k++) step();
    check_small("sat_20", 9'd20, 1'b1, 4'd15);

    // Asynchronous reset between edges mid-run.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    check("rst_launch", 9'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 37; k++) step();
    check("rst_pc37", 9'd37, 1'b1, 1'b0, 1'b0, 16'd37);
    #1 rst = 1'b1;
    #1 check("rst_async", 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    check("rst_idle", 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    check("rst_rerun0", 9'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    check("rst_rerun1", 9'd1, 1'b1, 1'b0, 1'b0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
